bidir_initiator: RTL and testbench
==================================

BIDIR_INITIATOR -- requirements
Module: bidir_initiator

Interface
REQ-001 Parameter DATA_W, default 8, bits per transfer in each direction; legal range 2..32.
REQ-002 Parameter TURNAROUND, default 2, bus-released idle cycles between the transmit and receive phases; legal range 1..15.
REQ-003 Port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port i_rst  input  1  reset, asynchronous assert, active-high.
REQ-005 Port i_start  input  1  request a transaction; sampled only in IDLE.
REQ-006 Port i_tx_data  input  DATA_W  word to send; latched on the edge that accepts i_start.
REQ-007 Port o_stb  output  1  one-cycle frame strobe to the responder.
REQ-008 Port io_data  inout  1  shared serial line; driven only in TX, otherwise high-impedance.
REQ-009 Port o_oe  output  1  high exactly while io_data is driven.
REQ-010 Port o_busy  output  1  high from STB through RX inclusive.
REQ-011 Port o_done  output  1  one-cycle pulse; o_rx_data is valid in that cycle.
REQ-012 Port o_rx_data  output  DATA_W  received word; holds until the next o_done.
REQ-013 Port o_mismatch  output  1  compare result; see Configuration.

Function
REQ-014 The FSM SHALL have states IDLE, STB, TX, TURN, RX and DONE, with the transitions given in REQ-015 to REQ-020.
REQ-015 IDLE with i_start=1 SHALL go to STB and latch i_tx_data into the shift register; otherwise it SHALL stay in IDLE.
REQ-016 STB SHALL last one cycle with o_stb=1, then go to TX.
REQ-017 TX SHALL last DATA_W cycles, driving bit DATA_W-1-k of the latched word on io_data in the k-th cycle (MSB first), with o_oe=1, then go to TURN.
REQ-018 TURN SHALL last TURNAROUND cycles with io_data released, then go to RX.
REQ-019 RX SHALL last DATA_W cycles, shifting io_data into the receive register (MSB first) at the rising edge that ends each cycle, then go to DONE.
REQ-020 DONE SHALL last one cycle with o_done=1 and o_rx_data updated, then go to IDLE.
REQ-021 o_done SHALL assert 2*DATA_W+TURNAROUND+1 edges after the edge that accepts i_start (19 for defaults).
REQ-022 i_start SHALL be ignored in every state except IDLE, including DONE; back-to-back transactions therefore have a minimum of one IDLE cycle between them.
REQ-023 Changes on i_tx_data after acceptance SHALL NOT affect the transmitted word.
REQ-024 Z or X sampled in RX SHALL be captured as-is; there is no filtering.
REQ-025 io_data, o_oe and o_stb SHALL be decoded from registered state only, so that no glitches occur at the TX-to-TURN boundary.

Reset
REQ-026 On i_rst=1 the block SHALL immediately, without waiting for a clock edge, enter IDLE, release io_data and clear o_oe, o_stb, o_busy, o_done, o_mismatch, o_rx_data and all counters to 0.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction with no o_done pulse, and o_rx_data SHALL read 0.
REQ-028 After i_rst deasserts, the first edge with i_start=1 SHALL start a normal transaction.

Configuration
REQ-029 With macro BIDIR_INITIATOR_CHECK_EN defined, o_mismatch SHALL be registered in DONE as (o_rx_data != transmitted word) and held until the next DONE or reset.
REQ-030 Without BIDIR_INITIATOR_CHECK_EN, o_mismatch SHALL be constant 0 and the transmitted-word copy and comparator SHALL NOT be synthesised.

Verification
REQ-031 Echo responder model, defaults, i_tx_data=8'h81 -> o_stb at edge+1, TX line pattern 1,0,0,0,0,0,0,1, o_done at edge+19, o_rx_data=8'h81, o_mismatch=0.
REQ-032 Responder returns 8'h7E for sent 8'h81, CHECK_EN defined -> o_rx_data=8'h7E, o_mismatch=1; same stimulus without CHECK_EN -> o_mismatch=0.
REQ-033 i_start held high continuously -> transactions repeat with one IDLE cycle between DONE and the next STB; pulses of i_start during busy cycles have no effect.
REQ-034 i_rst pulsed during the 4th TX cycle -> io_data goes to Z and o_oe goes to 0 within the reset pulse, no o_done occurs, and the next start with 8'hA5 completes normally.
REQ-035 TURNAROUND=1, DATA_W=4, send 4'hC -> o_done at edge+10, o_rx_data=4'hC, and io_data is never driven by both ends in the same cycle.

Source files
------------

// File: rtl/bidir_initiator.sv
// bidir_initiator: half-duplex serial initiator on a single shared line.
// A transaction sends one DATA_W-bit word MSB first and then receives one
// word back MSB first. Between the two phases the line is released for
// TURNAROUND cycles.
//
// Ports
//   i_clk       sole clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_start     transaction request, sampled only in IDLE
//   i_tx_data   word to send, latched when i_start is accepted
//   o_stb       one-cycle frame strobe to the responder
//   io_data     shared serial line, driven only during TX
//   o_oe        high exactly while io_data is driven
//   o_busy      high from STB through RX inclusive
//   o_done      one-cycle pulse; o_rx_data is valid in that cycle
//   o_rx_data   received word, held until the next o_done
//   o_mismatch  received word differs from the sent word
//
// Optional feature: define BIDIR_INITIATOR_CHECK_EN to build the echo
// comparator behind o_mismatch. Without it o_mismatch is tied to 0.
module bidir_initiator #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned TURNAROUND = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_tx_data,
   output logic              o_stb,
   inout  wire               io_data,
   output logic              o_oe,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_mismatch
);

   localparam int unsigned CNT_MAX = (DATA_W > TURNAROUND) ? DATA_W : TURNAROUND;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned RX_W    = DATA_W - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STB,
      S_TX,
      S_TURN,
      S_RX,
      S_DONE
   } state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_nx;
   logic [DATA_W-1:0]       tx_sh;
   // Holds the first DATA_W-1 received bits; the last bit joins on the DONE edge.
   logic [RX_W-1:0]         rx_sh;
   logic                    accept;
   logic                    rx_last;
   logic [DATA_W-1:0]       rx_word;

   assign accept  = (state == S_IDLE) && i_start;
   assign rx_last = (state == S_RX) && (state_nx == S_DONE);
   assign rx_word = {rx_sh, io_data};

   // Line driven straight from flops so the TX/TURN boundary cannot glitch.
   assign io_data = o_oe ? tx_sh[DATA_W-1] : 1'bz;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state and phase counter
   always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      case (state)
         S_IDLE: if (i_start) state_nx = S_STB;
         S_STB:  state_nx = S_TX;
         S_TX: begin
            if (cnt == CNT_W'(DATA_W - 1)) state_nx = S_TURN;
            else                           cnt_nx   = cnt + CNT_W'(1);
         end
         S_TURN: begin
            if (cnt == CNT_W'(TURNAROUND - 1)) state_nx = S_RX;
            else                               cnt_nx   = cnt + CNT_W'(1);
         end
         S_RX: begin
            if (cnt == CNT_W'(DATA_W - 1)) state_nx = S_DONE;
            else                           cnt_nx   = cnt + CNT_W'(1);
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Registered status outputs, decoded from the next state
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_stb  <= 1'b0;
         o_oe   <= 1'b0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         o_stb  <= (state_nx == S_STB);
         o_oe   <= (state_nx == S_TX);
         o_busy <= (state_nx == S_STB) || (state_nx == S_TX) ||
                   (state_nx == S_TURN) || (state_nx == S_RX);
         o_done <= (state_nx == S_DONE);
      end
   end

   // Transmit shifter: loaded on accept, shifts once per TX cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tx_sh <= '0;
      end else if (accept) begin
         tx_sh <= i_tx_data;
      end else if (state == S_TX) begin
         tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
      end
   end

   // Receive shifter and output word; line value is captured unfiltered
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_sh     <= '0;
         o_rx_data <= '0;
      end else if (state == S_RX) begin
         rx_sh <= RX_W'(rx_word);
         if (rx_last) o_rx_data <= rx_word;
      end
   end

`ifdef BIDIR_INITIATOR_CHECK_EN
   logic [DATA_W-1:0] tx_copy;

   // Copy of the sent word, compared against the received word on entry to DONE
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tx_copy    <= '0;
         o_mismatch <= 1'b0;
      end else begin
         if (accept)  tx_copy    <= i_tx_data;
         if (rx_last) o_mismatch <= (rx_word != tx_copy);
      end
   end
`else
   assign o_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_bidir_initiator.sv
// Directed bench for bidir_initiator: an echo/fixed-reply responder on the
// default instance, and a hand-sequenced responder on a DATA_W=4,
// TURNAROUND=1 instance.
module tb_bidir_initiator;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] tx_data;
   wire        io_data;
   logic       stb, oe, busy, done, mismatch;
   logic [7:0] rx_data;

   logic       start4;
   logic [3:0] tx_data4;
   wire        io4;
   logic       stb4, oe4, busy4, done4, mismatch4;
   logic [3:0] rx_data4;

   // responder state
   logic       resp_oe  = 1'b0;
   logic       resp_bit = 1'b0;
   logic       resp_fixed = 1'b0;
   logic [7:0] resp_val = 8'h00;
   logic [7:0] tx_cap_last = 8'h00;
   int         rst_cnt = 0;

   logic       r4_oe  = 1'b0;
   logic       r4_bit = 1'b0;

   int n_vec = 0;
   int n_bad = 0;

`ifdef BIDIR_INITIATOR_CHECK_EN
   localparam logic EXP_MM_FIXED = 1'b1;
`else
   localparam logic EXP_MM_FIXED = 1'b0;
`endif

   assign io_data = resp_oe ? resp_bit : 1'bz;
   assign io4     = r4_oe   ? r4_bit   : 1'bz;

   always #5 clk = ~clk;

   bidir_initiator #(.DATA_W(8), .TURNAROUND(2)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_tx_data(tx_data),
      .o_stb(stb), .io_data(io_data), .o_oe(oe), .o_busy(busy),
      .o_done(done), .o_rx_data(rx_data), .o_mismatch(mismatch)
   );

   bidir_initiator #(.DATA_W(4), .TURNAROUND(1)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_start(start4), .i_tx_data(tx_data4),
      .o_stb(stb4), .io_data(io4), .o_oe(oe4), .o_busy(busy4),
      .o_done(done4), .o_rx_data(rx_data4), .o_mismatch(mismatch4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge rst) rst_cnt++;

   // Responder on the default instance: captures TX bits, replies after the turnaround
   always begin
      @(negedge clk);
      if (stb && !rst) begin
         automatic int   rc    = rst_cnt;
         automatic bit   abort = 1'b0;
         automatic logic [7:0] cap = 8'h00;
         automatic logic [7:0] reply;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rst_cnt != rc) begin
               abort = 1'b1;
               break;
            end
            check("tx_oe", 32'(oe), 32'd1);
            cap = {cap[6:0], io_data};
         end
         if (!abort) begin
            tx_cap_last = cap;
            reply = resp_fixed ? resp_val : cap;
            repeat (3) @(posedge clk);
            for (int j = 0; j < 8; j++) begin
               #1;
               resp_bit = reply[7-j];
               resp_oe  = 1'b1;
               check("rx_no_contention", 32'(oe), 32'd0);
               @(posedge clk);
            end
            #1 resp_oe = 1'b0;
         end
      end
   end

   // One transaction on the default instance with latency, data and compare checks
   task automatic run_txn(input logic [7:0] data, input logic fixed, input logic [7:0] val,
                          input logic [7:0] exp_rx, input logic exp_mm);
      int n;
      @(negedge clk);
      tx_data    = data;
      resp_fixed = fixed;
      resp_val   = val;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      tx_data = ~data;
      check("stb_after_accept", 32'(stb), 32'd1);
      check("busy_after_accept", 32'(busy), 32'd1);
      n = 0;
      repeat (40) begin
         @(posedge clk);
         n++;
         #1;
         if (done) break;
      end
      check("done_latency", 32'(n), 32'd19);
      check("tx_line_pattern", 32'(tx_cap_last), 32'(data));
      check("rx_data", 32'(rx_data), 32'(exp_rx));
      check("mismatch", 32'(mismatch), 32'(exp_mm));
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("rx_hold", 32'(rx_data), 32'(exp_rx));
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; tx_data = 8'h00;
      start4 = 1'b0; tx_data4 = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stb", 32'(stb), 32'd0);
      check("rst_oe", 32'(oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_mismatch", 32'(mismatch), 32'd0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);

      // Echo of 8'h81
      run_txn(8'h81, 1'b0, 8'h00, 8'h81, 1'b0);
      // Responder returns 8'h7E for 8'h81
      run_txn(8'h81, 1'b1, 8'h7E, 8'h7E, EXP_MM_FIXED);
      // Echo clears the compare flag again
      run_txn(8'h5C, 1'b0, 8'h00, 8'h5C, 1'b0);

      // i_start held high: one IDLE cycle between DONE and next STB
      @(negedge clk);
      resp_fixed = 1'b0;
      tx_data    = 8'h5A;
      start      = 1'b1;
      @(posedge clk);
      #1;
      tx_data = 8'h00;
      check("held_stb", 32'(stb), 32'd1);
      n = 0;
      repeat (40) begin
         @(posedge clk); n++; #1;
         if (done) break;
      end
      check("held_latency1", 32'(n), 32'd19);
      check("held_rx1", 32'(rx_data), 32'h5A);
      tx_data = 8'h3C;
      @(posedge clk);
      #1;
      check("held_gap_stb", 32'(stb), 32'd0);
      check("held_gap_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check("held_restart_stb", 32'(stb), 32'd1);
      tx_data = 8'hFF;
      n = 0;
      repeat (40) begin
         @(posedge clk); n++; #1;
         if (n == 5) start = 1'b0;
         if (done) break;
      end
      check("held_latency2", 32'(n), 32'd19);
      check("held_rx2", 32'(rx_data), 32'h3C);

      // Reset in the 4th TX cycle aborts the transaction
      @(negedge clk);
      tx_data = 8'h96;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_oe", 32'(oe), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rx_data", 32'(rx_data), 32'd0);
      #3 rst = 1'b0;
      n = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done) n++;
      end
      check("abort_no_done", 32'(n), 32'd0);
      run_txn(8'hA5, 1'b0, 8'h00, 8'hA5, 1'b0);

      // DATA_W=4, TURNAROUND=1 instance sending 4'hC, echoed by hand
      begin
         logic [3:0] cap4;
         cap4 = 4'h0;
         @(negedge clk);
         tx_data4 = 4'hC;
         start4   = 1'b1;
         @(posedge clk);
         #1 start4 = 1'b0;
         check("w4_stb", 32'(stb4), 32'd1);
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("w4_tx_oe", 32'(oe4), 32'd1);
            cap4 = {cap4[2:0], io4};
         end
         check("w4_tx_pattern", 32'(cap4), 32'hC);
         @(posedge clk);
         #1;
         check("w4_turn_oe", 32'(oe4), 32'd0);
         @(posedge clk);
         for (int j = 0; j < 4; j++) begin
            #1;
            check("w4_rx_no_contention", 32'(oe4), 32'd0);
            check("w4_no_early_done", 32'(done4), 32'd0);
            r4_bit = cap4[3-j];
            r4_oe  = 1'b1;
            @(posedge clk);
         end
         #1 r4_oe = 1'b0;
         check("w4_done_at_10", 32'(done4), 32'd1);
         check("w4_rx_data", 32'(rx_data4), 32'hC);
         check("w4_mismatch", 32'(mismatch4), 32'd0);
      end

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
